// File: rtl/adc_echo_capture.sv
// ---------------------------------------------------------------------------
// adc_echo_capture
//
// Purpose:
//   Consumer of the ADC acquisition-enable window. While the window is open
//   the ADC words are captured, packed two per 32-bit word (earlier sample in
//   the low half) and pushed into the acquisition FIFO. Each window is one
//   echo; after the programmed number of echoes the block pulses DONE.
//   Words that arrive while the FIFO is full are dropped and a sticky
//   OVERFLOW flag is raised.
//
// Build option:
//   ADC_CAPTURE_TAG_EN - when defined, every echo starts with a header word
//                        {16'hECE0, echo index} written in the same cycle that
//                        the first sample of the echo is stored.
//
// Parameters:
//   ADC_WIDTH       ADC sample width (max 16); zero-extended into a 16 b field
//   ECHO_CNT_WIDTH  width of NUM_ECHOES_i / ECHO_CNT_o
//
// Ports:
//   CLK             system clock, ADC_DATA_i synchronous to it
//   RESET           asynchronous, active-high reset
//   ARM_i           1-cycle pulse: clear counters/flags and start a new scan
//   NUM_ECHOES_i    echoes per scan, sampled on ARM_i
//   ACQ_EN_i        acquisition window from the ADC window generator
//   ADC_DATA_i      ADC sample, valid every cycle
//   FIFO_FULL_i     acquisition FIFO full
//   FIFO_WR_EN_o    FIFO write strobe, one cycle per word
//   FIFO_WR_DATA_o  {later sample, earlier sample}
//   ECHO_CNT_o      echoes completed in the current scan
//   BUSY_o          high from ARM until DONE
//   DONE_o          1-cycle pulse after the last echo has been written
//   OVERFLOW_o      sticky: a word was dropped on FIFO full, cleared by ARM
// ---------------------------------------------------------------------------
module adc_echo_capture #(
  parameter int ADC_WIDTH      = 16,
  parameter int ECHO_CNT_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      ARM_i,
  input  logic [ECHO_CNT_WIDTH-1:0] NUM_ECHOES_i,
  input  logic                      ACQ_EN_i,
  input  logic [ADC_WIDTH-1:0]      ADC_DATA_i,
  input  logic                      FIFO_FULL_i,
  output logic                      FIFO_WR_EN_o,
  output logic [31:0]               FIFO_WR_DATA_o,
  output logic [ECHO_CNT_WIDTH-1:0] ECHO_CNT_o,
  output logic                      BUSY_o,
  output logic                      DONE_o,
  output logic                      OVERFLOW_o
);

  // Scan sequencer states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ECHO = 2'd1;
  localparam logic [1:0] ST_CAPTURE   = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  localparam logic [15:0] TAG_MARKER = 16'hECE0;

  // Registered input copies; every decision below is taken on these so the
  // ADC pins see exactly one flop of load and a clean timing path.
  logic                      acqEn_q;
  logic                      acqEnPrev_q;
  logic [15:0]               adcData_q;

  // Sequencer and packing state
  logic [1:0]                state_q,     state_d;
  logic                      half_q,      half_d;
  logic [15:0]               lowSample_q, lowSample_d;
  logic [ECHO_CNT_WIDTH-1:0] numEchoes_q, numEchoes_d;
  logic [ECHO_CNT_WIDTH-1:0] echoCnt_q,   echoCnt_d;

  // Output registers
  logic                      busy_q,      busy_d;
  logic                      done_q,      done_d;
  logic                      overflow_q,  overflow_d;
  logic                      wrEn_q,      wrEn_d;
  logic [31:0]               wrData_q,    wrData_d;

  // Combinational helpers
  logic                      acqRise;
  logic [ECHO_CNT_WIDTH-1:0] echoCntInc;
  logic                      wordDue;
  logic [31:0]               wordVal;

  // A new echo is recognised only on a 0->1 transition of the registered
  // window, so a window that was already open when the scan was armed is
  // skipped until it closes and opens again.
  assign acqRise    = acqEn_q & ~acqEnPrev_q;
  assign echoCntInc = echoCnt_q + ECHO_CNT_WIDTH'(1);

  // Input stage: window and sample are registered unconditionally every
  // cycle; the sample is zero-extended into the 16 b packing field.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acqEn_q     <= 1'b0;
      acqEnPrev_q <= 1'b0;
      adcData_q   <= 16'h0000;
    end else begin
      acqEn_q     <= ACQ_EN_i;
      acqEnPrev_q <= acqEn_q;
      adcData_q   <= 16'(ADC_DATA_i);
    end
  end

  // Next-state logic. ARM has priority over everything: it restarts the scan
  // from any state, discards a half-filled word and never pulses DONE.
  // Inside a scan the FSM only decides *whether* a word is due and what it
  // holds; the common tail then either writes it or, when the FIFO is full,
  // drops it and records the overflow. Pairing and echo counting carry on
  // regardless of drops.
  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    lowSample_d = lowSample_q;
    numEchoes_d = numEchoes_q;
    echoCnt_d   = echoCnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    wrEn_d      = 1'b0;
    wrData_d    = wrData_q;
    wordDue     = 1'b0;
    wordVal     = 32'h0000_0000;

    if (ARM_i) begin
      numEchoes_d = NUM_ECHOES_i;
      echoCnt_d   = '0;
      overflow_d  = 1'b0;
      half_d      = 1'b0;
      busy_d      = 1'b1;
      state_d     = (NUM_ECHOES_i == '0) ? ST_DONE : ST_WAIT_ECHO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_WAIT_ECHO: begin
          if (acqRise) begin
`ifdef ADC_CAPTURE_TAG_EN
            // Header carries the index of the echo about to be captured.
            wordDue = 1'b1;
            wordVal = {TAG_MARKER, 16'(echoCnt_q)};
`else
            wordDue = 1'b0;
`endif
            lowSample_d = adcData_q;
            half_d      = 1'b1;
            state_d     = ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (acqEn_q) begin
            if (!half_q) begin
              lowSample_d = adcData_q;
              half_d      = 1'b1;
            end else begin
              wordDue = 1'b1;
              wordVal = {adcData_q, lowSample_q};
              half_d  = 1'b0;
            end
          end else begin
            // Window closed: an odd sample left over goes out padded with
            // zeros in the upper half, then the echo is counted.
            if (half_q) begin
              wordDue = 1'b1;
              wordVal = {16'h0000, lowSample_q};
              half_d  = 1'b0;
            end
            echoCnt_d = echoCntInc;
            state_d   = (echoCntInc == numEchoes_q) ? ST_DONE : ST_WAIT_ECHO;
          end
        end

        ST_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (wordDue) begin
      if (FIFO_FULL_i) begin
        overflow_d = 1'b1;
      end else begin
        wrEn_d   = 1'b1;
        wrData_d = wordVal;
      end
    end
  end

  // State and output registers; reset returns everything to zero at once,
  // losing any partially packed word.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      half_q      <= 1'b0;
      lowSample_q <= 16'h0000;
      numEchoes_q <= '0;
      echoCnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      wrEn_q      <= 1'b0;
      wrData_q    <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      lowSample_q <= lowSample_d;
      numEchoes_q <= numEchoes_d;
      echoCnt_q   <= echoCnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      wrEn_q      <= wrEn_d;
      wrData_q    <= wrData_d;
    end
  end

  assign FIFO_WR_EN_o   = wrEn_q;
  assign FIFO_WR_DATA_o = wrData_q;
  assign ECHO_CNT_o     = echoCnt_q;
  assign BUSY_o         = busy_q;
  assign DONE_o         = done_q;
  assign OVERFLOW_o     = overflow_q;

endmodule
